// File: rtl/complex_prog_mem.sv
// complex_prog_mem: 32x16 program/data memory with byte-serial loader feeding the complex pipeline controller
// Optional memory dump (DUMP/HALT) enabled by COMPLEX_PROG_MEM_DUMP_EN
module complex_prog_mem #(
    parameter int ADDR_W = 5,
    parameter int LAST_WORD = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              readwriteN,
    input  logic [15:0]       data_out,
    output logic [15:0]       data_in,
    input  logic              dump_req,
    output logic              dump_valid,
    output logic [7:0]        dump_byte,
    input  logic              dump_ready
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic [2:0] {LOAD_HI, LOAD_LO, RUN, DUMP, HALT} state_t;
    state_t state, state_nx;
    logic [15:0] mem [DEPTH];
    logic [ADDR_W-1:0] ptr;
    logic [7:0] hi_hold;
    logic load_hs, wr_en;
    assign load_hs = load_valid & load_ready;
    assign wr_en = state == RUN && !readwriteN;
    assign data_in = mem[address];
`ifdef COMPLEX_PROG_MEM_DUMP_EN
    logic [ADDR_W:0] di, di_nx;
    logic [15:0] first_word, nx_word;
    assign di_nx = di + 1'b1;
    // a controller write landing with dump_req must show up in the first dumped byte
    assign first_word = (wr_en && address == '0) ? data_out : mem[0];
    assign nx_word = mem[di_nx[ADDR_W:1]];
`endif
    always_comb begin
        state_nx = state;
        if (state == LOAD_HI && load_hs)
            state_nx = LOAD_LO;
        else if (state == LOAD_LO && load_hs)
            state_nx = (load_last || ptr == ADDR_W'(LAST_WORD)) ? RUN : LOAD_HI;
`ifdef COMPLEX_PROG_MEM_DUMP_EN
        else if (state == RUN && dump_req)
            state_nx = DUMP;
        else if (state == DUMP && dump_valid && dump_ready && di == '1)
            state_nx = HALT;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD_HI;
            ptr <= '0;
            hi_hold <= '0;
            load_ready <= 1'b1;
            cpu_rst <= 1'b1;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_nx;
            load_ready <= state_nx == LOAD_HI || state_nx == LOAD_LO;
            cpu_rst <= state_nx != RUN;
            if (state == LOAD_HI && load_hs) hi_hold <= load_byte;
            if (state == LOAD_LO && load_hs) begin
                mem[ptr] <= {hi_hold, load_byte};
                ptr <= ptr + 1'b1;
            end
            if (wr_en) mem[address] <= data_out;
        end
    end
`ifdef COMPLEX_PROG_MEM_DUMP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dump_valid <= 1'b0;
            dump_byte <= '0;
            di <= '0;
        end else if (state == RUN && dump_req) begin
            dump_valid <= 1'b1;
            dump_byte <= first_word[15:8];
            di <= '0;
        end else if (state == DUMP && dump_valid && dump_ready) begin
            di <= di_nx;
            dump_valid <= di != '1;
            dump_byte <= di == '1 ? 8'h00 : (di_nx[0] ? nx_word[7:0] : nx_word[15:8]);
        end
    end
`else
    logic unused;
    assign unused = dump_req ^ dump_ready;
    assign dump_valid = 1'b0;
    assign dump_byte = '0;
`endif
endmodule

// File: tb/tb_complex_prog_mem.sv
// tb_complex_prog_mem: directed scoreboard bench for complex_prog_mem
module tb_complex_prog_mem;
    logic clk = 0;
    logic rst = 1;
    logic load_valid = 0, load_last = 0, readwriteN = 1, dump_req = 0, dump_ready = 0;
    logic [7:0] load_byte = 0;
    logic [4:0] address = 0;
    logic [15:0] data_out = 0;
    logic load_ready, cpu_rst, dump_valid;
    logic [15:0] data_in;
    logic [7:0] dump_byte;
    logic [15:0] model [32];
    logic [15:0] exp_q [$];
    int total = 0, bad = 0;

    complex_prog_mem dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_byte(load_byte),
        .load_last(load_last), .load_ready(load_ready), .cpu_rst(cpu_rst),
        .address(address), .readwriteN(readwriteN), .data_out(data_out),
        .data_in(data_in), .dump_req(dump_req), .dump_valid(dump_valid),
        .dump_byte(dump_byte), .dump_ready(dump_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1;
        step;
        step;
        rst = 0;
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        load_valid = 1;
        load_byte = b;
        load_last = l;
        step;
        load_valid = 0;
        load_last = 0;
    endtask

    task automatic read_check(input int a);
        exp_q.push_back(model[a]);
        address = 5'(a);
        #1;
        check($sformatf("mem[%0d]", a), data_in, exp_q.pop_front());
    endtask

    task automatic check_mem;
        for (int a = 0; a < 32; a++) read_check(a);
    endtask

    initial begin
        // test 1: short image with load_last
        do_reset;
        check("rst_load_ready", 16'(load_ready), 16'h1);
        check("rst_cpu_rst", 16'(cpu_rst), 16'h1);
        check("rst_dump_valid", 16'(dump_valid), 16'h0);
        check("rst_dump_byte", 16'(dump_byte), 16'h0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        check("t1_cpu_rst_pre", 16'(cpu_rst), 16'h1);
        send_byte(8'h78, 1);
        model[0] = 16'h1234;
        model[1] = 16'h5678;
        check("t1_cpu_rst_run", 16'(cpu_rst), 16'h0);
        check("t1_load_ready_run", 16'(load_ready), 16'h0);
        check_mem;
`ifdef COMPLEX_PROG_MEM_DUMP_EN
        begin
            int cyc = 0;
            for (int k = 0; k < 64; k++)
                exp_q.push_back({8'h00, k[0] ? model[k/2][7:0] : model[k/2][15:8]});
            dump_req = 1;
            step;
            dump_req = 0;
            check("dump_cpu_rst_enter", 16'(cpu_rst), 16'h1);
            while (exp_q.size() > 0 && cyc < 400) begin
                dump_ready = cyc[0];
                if (dump_valid && dump_ready) begin
                    check("dump_byte", 16'(dump_byte), exp_q.pop_front());
                    check("dump_cpu_rst", 16'(cpu_rst), 16'h1);
                end
                step;
                cyc++;
            end
            check("dump_remaining", 16'(exp_q.size()), 16'h0);
            exp_q.delete();
            dump_ready = 0;
            check("halt_dump_valid", 16'(dump_valid), 16'h0);
            check("halt_cpu_rst", 16'(cpu_rst), 16'h1);
            check("halt_load_ready", 16'(load_ready), 16'h0);
        end
`else
        dump_req = 1;
        dump_ready = 1;
        step;
        dump_req = 0;
        dump_ready = 0;
        check("nodump_valid", 16'(dump_valid), 16'h0);
        check("nodump_cpu_rst", 16'(cpu_rst), 16'h0);
`endif

        // test 2: full 64-byte image, auto-completion
        do_reset;
        for (int k = 0; k < 32; k++) begin
            send_byte(8'(k), 0);
            send_byte(~8'(k), 0);
            model[k] = {8'(k), ~8'(k)};
            if (k == 30) check("t2_cpu_rst_pre", 16'(cpu_rst), 16'h1);
        end
        check("t2_cpu_rst_run", 16'(cpu_rst), 16'h0);
        load_valid = 1;
        load_byte = 8'hFF;
        #1;
        check("t2_65th_ready", 16'(load_ready), 16'h0);
        step;
        load_valid = 0;
        check_mem;

        // test 3: controller write in RUN, read-during-write returns old word
        address = 7;
        readwriteN = 0;
        data_out = 16'hA5C3;
        exp_q.push_back(model[7]);
        #1;
        check("t3_old_word", data_in, exp_q.pop_front());
        step;
        readwriteN = 1;
        model[7] = 16'hA5C3;
        read_check(7);
        read_check(8);

        // test 4: gaps, load_last on high byte, writes ignored while loading
        do_reset;
        address = 5;
        readwriteN = 0;
        data_out = 16'hFFFF;
        send_byte(8'hAB, 1);
        check("t4_ready_after_hi_last", 16'(load_ready), 16'h1);
        step;
        step;
        send_byte(8'hCD, 0);
        send_byte(8'h11, 1);
        check("t4_cpu_rst_hi_last", 16'(cpu_rst), 16'h1);
        send_byte(8'h22, 1);
        readwriteN = 1;
        model[0] = 16'hABCD;
        model[1] = 16'h1122;
        check("t4_cpu_rst_run", 16'(cpu_rst), 16'h0);
        check_mem;

        // test 5: reset mid-load discards partial image
        do_reset;
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        do_reset;
        check("t5_cpu_rst_after_rst", 16'(cpu_rst), 16'h1);
        send_byte(8'hBE, 0);
        check("t5_cpu_rst_mid", 16'(cpu_rst), 16'h1);
        send_byte(8'hEF, 1);
        model[0] = 16'hBEEF;
        check("t5_cpu_rst_run", 16'(cpu_rst), 16'h0);
        read_check(0);
        read_check(1);
        read_check(31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/complex_prog_mem.md
Name: complex_prog_mem

Overview:
- 32 x 16-bit unified program/data memory that directly feeds the complex-number pipeline controller.
- Supplies instruction and operand words on the controller's memory port and accepts its result writes.
- Before execution, a byte-serial loader interface fills the memory from the host. The block holds the controller in reset until loading completes.

Parameters:
- ADDR_W, 5, word address width; depth = 2**ADDR_W = 32 words.
- LAST_WORD, 31, highest word index written by the loader before auto-completion.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- load_valid  input  1  host offers load_byte this cycle.
- load_byte  input  8  load byte; high byte of each word first.
- load_last  input  1  with a low byte: final word of image.
- load_ready  output  1  block accepts load_byte this cycle.
- cpu_rst  output  1  reset to controller; high while not in RUN.
- address  input  ADDR_W  controller word address.
- readwriteN  input  1  1 = read, 0 = write.
- data_out  input  16  controller write data.
- data_in  output  16  read data to controller.
- dump_req  input  1  pulse: freeze controller and stream memory out (DUMP_EN only).
- dump_valid  output  1  dump_byte is valid.
- dump_byte  output  8  dumped byte; high byte first.
- dump_ready  input  1  host consumes dump_byte.

Behaviour:
- Reset (rst high at posedge), all registered:
  - state=LOAD_HI, word pointer=0, hi-hold=0, all 32 words cleared to 0.
  - load_ready=1, cpu_rst=1, dump_valid=0, dump_byte=0.
  - rst mid-load or mid-dump aborts immediately; the memory is cleared.
- States: LOAD_HI, LOAD_LO, RUN, DUMP, HALT.
- LOAD_HI:
  - On load_valid & load_ready, store byte in hi-hold and go to LOAD_LO.
  - load_last is ignored in this state.
- LOAD_LO:
  - On a handshake, write mem[ptr] = {hi-hold, byte}.
  - If load_last=1 or ptr==LAST_WORD, go to RUN.
  - Otherwise ptr+1 and go to LOAD_HI.
  - Unloaded words remain 0.
- load_ready=1 in LOAD_HI/LOAD_LO, 0 otherwise. Bytes offered outside the load states are dropped.
- cpu_rst is registered: 1 in every state except RUN. It falls in the first cycle state==RUN (the cycle after the final byte handshake).
- data_in = mem[address], combinational (asynchronous read).
  - The controller registers address and samples data_in on the next edge, so effective read latency is 1 cycle from the address update.
- Writes: in RUN only, at posedge when readwriteN==0, mem[address] <= data_out.
  - Read of the same address in the same cycle returns the old word; the new word is visible the following cycle.
  - In all other states readwriteN/data_out are ignored.
- Address wraps naturally at ADDR_W bits. No out-of-range condition exists.
- RUN persists until rst, or dump_req when DUMP_EN.

Optional Feature:
- Macro: COMPLEX_PROG_MEM_DUMP_EN.
- With the macro defined:
  - dump_req=1 in RUN moves to DUMP and raises cpu_rst next cycle.
  - A controller write in the same cycle as dump_req is still committed.
  - DUMP streams mem[0][15:8], mem[0][7:0], ... mem[31][7:0] (64 bytes).
  - dump_valid is held with a stable dump_byte until dump_ready; the byte advances on valid & ready.
  - After the 64th handshake, dump_valid=0 and state=HALT (cpu_rst=1, load_ready=0) until rst.
  - dump_req outside RUN is ignored.
- Without the macro:
  - The DUMP/HALT logic is absent.
  - dump_valid and dump_byte are constant 0; dump_req and dump_ready are ignored.

Test Plan:
- Reset then load bytes 0x12,0x34,0x56,0x78 with load_last on the 4th:
  - mem[0]=0x1234, mem[1]=0x5678, mem[2..31]=0.
  - cpu_rst falls the cycle after the 4th handshake; load_ready=0 thereafter.
- Load 64 bytes without load_last, words k=0..31 = {k, ~k}:
  - Auto-transition to RUN after byte 64.
  - A 65th load_valid is not accepted (load_ready=0).
- In RUN, address=7, readwriteN=0, data_out=0xA5C3 for one cycle, then readwriteN=1:
  - data_in=old mem[7] in the write cycle, 0xA5C3 the next cycle.
- Load gaps (load_valid toggling 1,0,0,1), plus load_last asserted on a high byte:
  - Word assembly is unaffected; load_last on the high byte is ignored; completion happens only on a low byte.
- Assert rst after 3 of 6 load bytes, then reload 0xBEEF with load_last:
  - mem[0]=0xBEEF, mem[1]=0, the partial word is discarded, cpu_rst=1 until RUN.
- (DUMP_EN) After the first test, pulse dump_req with dump_ready toggling every other cycle:
  - The bytes read 0x12,0x34,0x56,0x78, then 60 x 0x00; cpu_rst=1 throughout.
  - End in HALT with dump_valid=0.
